// File: rtl/bsg_manycore_pkg.sv
// Manycore shared definitions used by the return buffer.
//   bsg_manycore_reg_id_width_gp      : width of the destination register id
//   bsg_manycore_return_packet_type_e : kind of return packet arriving at a tile
package bsg_manycore_pkg;

  localparam int bsg_manycore_reg_id_width_gp = 5;

  typedef enum logic [1:0] {
    e_return_int_wb   = 2'd0,
    e_return_float_wb = 2'd1,
    e_return_ifetch   = 2'd2,
    e_return_credit   = 2'd3
  } bsg_manycore_return_packet_type_e;

endpackage

// File: rtl/vanilla_return_fifo_ar.sv
// 1-read/1-write return FIFO with asynchronous active-low reset.
//   clk_i, reset_n_i : clock, async active-low reset (pointers/occupancy only)
//   v_i, data_i      : write request; ignored while full
//   v_o, data_o      : head valid / head data (registered, no bypass)
//   yumi_i           : consume head; ignored while empty
//   full_o           : occupancy == els_p
module vanilla_return_fifo_ar #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               full_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                enq, deq;

  assign v_o    = (cnt_q != '0);
  assign full_o = (cnt_q == cnt_w_lp'(els_p));
  assign data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the write even if the head leaves this cycle.
  assign enq = v_i & ~full_o;
  assign deq = yumi_i & v_o;

  // els_p is a power of two, so natural pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; contents are meaningless while v_o is low.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vanilla_return_buffer.sv
// Return buffer of a vanilla core: queues returning load/ifetch data and
// tracks outstanding-request credits.
//   clk_i, reset_n_i     : clock, async active-low reset
//   in_*                 : return packet from the endpoint; in_yumi_o accepts it
//   out_v_i              : a remote request leaves the tile (uses one credit)
//   returned_*           : FIFO head towards the TX/response logic
//   returned_fifo_full_o : FIFO holds els_p entries
//   out_credits_o/avail  : credits available for new remote requests
module vanilla_return_buffer
  import bsg_manycore_pkg::*;
#(
  parameter int data_width_p      = 32,
  parameter int els_p             = 4,
  parameter int max_out_credits_p = 8,
  localparam int credit_counter_width_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    in_v_i,
  input  logic [data_width_p-1:0]                 in_data_i,
  input  logic [bsg_manycore_reg_id_width_gp-1:0] in_reg_id_i,
  input  bsg_manycore_return_packet_type_e        in_pkt_type_i,
  output logic                                    in_yumi_o,
  input  logic                                    out_v_i,
  output logic                                    returned_v_o,
  output logic [data_width_p-1:0]                 returned_data_o,
  output logic [bsg_manycore_reg_id_width_gp-1:0] returned_reg_id_o,
  output bsg_manycore_return_packet_type_e        returned_pkt_type_o,
  output logic                                    returned_fifo_full_o,
  input  logic                                    returned_yumi_i,
  output logic [credit_counter_width_lp-1:0]      out_credits_o,
  output logic                                    out_credits_avail_o
);

  localparam int type_w_lp  = $bits(bsg_manycore_return_packet_type_e);
  localparam int entry_w_lp = data_width_p + bsg_manycore_reg_id_width_gp + type_w_lp;
  localparam logic [credit_counter_width_lp-1:0] max_credits_lp =
    credit_counter_width_lp'(max_out_credits_p);

  logic                               is_credit;
  logic                               enq;
  logic [entry_w_lp-1:0]              enq_entry, head_entry;
  logic [credit_counter_width_lp-1:0] credits_q, credits_d;
  logic                               inc, dec;

  // Credit packets never need FIFO space, so they are accepted even when full.
  // Gating with reset keeps the handshake quiet while reset is held.
  assign is_credit = (in_pkt_type_i == e_return_credit);
  assign in_yumi_o = reset_n_i & in_v_i & (is_credit | ~returned_fifo_full_o);
  assign enq       = in_yumi_o & ~is_credit;
  assign enq_entry = {in_data_i, in_reg_id_i, in_pkt_type_i};

  vanilla_return_fifo_ar #(
    .width_p (entry_w_lp),
    .els_p   (els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (enq),
    .data_i    (enq_entry),
    .v_o       (returned_v_o),
    .data_o    (head_entry),
    .yumi_i    (returned_yumi_i),
    .full_o    (returned_fifo_full_o)
  );

  assign returned_data_o     = head_entry[entry_w_lp-1 -: data_width_p];
  assign returned_reg_id_o   = head_entry[type_w_lp +: bsg_manycore_reg_id_width_gp];
  assign returned_pkt_type_o = bsg_manycore_return_packet_type_e'(head_entry[type_w_lp-1:0]);

  // Every accepted return, credit or not, gives back one credit.
  assign inc = in_v_i & in_yumi_o;
  assign dec = out_v_i;

  always_comb begin
    credits_d = credits_q;
    if (inc && !dec && credits_q != max_credits_lp) credits_d = credits_q + credit_counter_width_lp'(1);
    if (dec && !inc && credits_q != '0)             credits_d = credits_q - credit_counter_width_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) credits_q <= max_credits_lp;
    else            credits_q <= credits_d;
  end

  assign out_credits_o       = credits_q;
  assign out_credits_avail_o = (credits_q != '0);

  // Simulation-side protocol checks; no state, ignored by synthesis.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (dec && !inc && credits_q == '0)
        $error("vanilla_return_buffer: credit underflow");
      if (inc && !dec && credits_q == max_credits_lp)
        $error("vanilla_return_buffer: credit overflow");
      if (returned_fifo_full_o && !returned_yumi_i)
        $warning("vanilla_return_buffer: return fifo full and not draining");
    end
  end

endmodule

// File: tb/tb_vanilla_return_buffer.sv
module tb_vanilla_return_buffer;
  import bsg_manycore_pkg::*;

  logic                                    clk = 1'b0;
  logic                                    rst_n;
  logic                                    in_v;
  logic [31:0]                             in_data;
  logic [bsg_manycore_reg_id_width_gp-1:0] in_reg;
  bsg_manycore_return_packet_type_e        in_type;
  logic                                    in_yumi;
  logic                                    out_v;
  logic                                    ret_v;
  logic [31:0]                             ret_data;
  logic [bsg_manycore_reg_id_width_gp-1:0] ret_reg;
  bsg_manycore_return_packet_type_e        ret_type;
  logic                                    ret_full;
  logic                                    ret_yumi;
  logic [3:0]                              credits;
  logic                                    credits_avail;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  vanilla_return_buffer #(
    .data_width_p      (32),
    .els_p             (4),
    .max_out_credits_p (8)
  ) dut (
    .clk_i                (clk),
    .reset_n_i            (rst_n),
    .in_v_i               (in_v),
    .in_data_i            (in_data),
    .in_reg_id_i          (in_reg),
    .in_pkt_type_i        (in_type),
    .in_yumi_o            (in_yumi),
    .out_v_i              (out_v),
    .returned_v_o         (ret_v),
    .returned_data_o      (ret_data),
    .returned_reg_id_o    (ret_reg),
    .returned_pkt_type_o  (ret_type),
    .returned_fifo_full_o (ret_full),
    .returned_yumi_i      (ret_yumi),
    .out_credits_o        (credits),
    .out_credits_avail_o  (credits_avail)
  );

  task automatic idle_inputs();
    in_v = 0; in_data = '0; in_reg = '0; in_type = e_return_int_wb;
    out_v = 0; ret_yumi = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (credits !== 4'd8) begin nmis++; $display("FAIL reset_credits got %0d want 8", credits); end
    nvec++; if (credits_avail !== 1'b1) begin nmis++; $display("FAIL reset_avail got %b want 1", credits_avail); end
    nvec++; if (ret_v !== 1'b0) begin nmis++; $display("FAIL reset_ret_v got %b want 0", ret_v); end
    nvec++; if (ret_full !== 1'b0) begin nmis++; $display("FAIL reset_full got %b want 0", ret_full); end
    nvec++; if (in_yumi !== 1'b0) begin nmis++; $display("FAIL reset_in_yumi got %b want 0", in_yumi); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    nvec++; if (credits !== 4'd8 || ret_v !== 1'b0) begin nmis++; $display("FAIL idle_after_reset credits %0d v %b want 8 0", credits, ret_v); end
  endtask

  task automatic test_credit_return();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_v = 1;
      @(posedge clk); #1;
      nvec++; if (credits !== 4'(7 - i)) begin nmis++; $display("FAIL out_v_dec[%0d] got %0d want %0d", i, credits, 7 - i); end
    end
    @(negedge clk); out_v = 0; in_v = 1; in_data = 32'hDEADBEEF; in_reg = 5; in_type = e_return_int_wb;
    #1;
    nvec++; if (in_yumi !== 1'b1) begin nmis++; $display("FAIL ret_accept got %b want 1", in_yumi); end
    nvec++; if (ret_v !== 1'b0) begin nmis++; $display("FAIL no_bypass got %b want 0", ret_v); end
    @(posedge clk); #1;
    nvec++; if (credits !== 4'd6) begin nmis++; $display("FAIL ret_credit_inc got %0d want 6", credits); end
    nvec++; if (ret_v !== 1'b1 || ret_data !== 32'hDEADBEEF || ret_reg !== 5'd5 || ret_type !== e_return_int_wb)
      begin nmis++; $display("FAIL head_after_1 got v %b %h/%0d want 1 deadbeef/5", ret_v, ret_data, ret_reg); end
    @(negedge clk); in_v = 0; ret_yumi = 1;
    @(posedge clk); #1;
    nvec++; if (ret_v !== 1'b0) begin nmis++; $display("FAIL drain_one got v %b want 0", ret_v); end
    @(negedge clk); ret_yumi = 0;
  endtask

  // Enters with credits=6; brings credits down so four returns fit.
  task automatic test_full();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); out_v = 1;
      @(posedge clk);
    end
    #1;
    nvec++; if (credits !== 4'd2) begin nmis++; $display("FAIL pre_full_credits got %0d want 2", credits); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); out_v = 0; in_v = 1; d = 32'hA + 32'(i); in_data = d; in_reg = 5'(i); in_type = e_return_int_wb;
      #1;
      nvec++; if (in_yumi !== 1'b1) begin nmis++; $display("FAIL fill_accept[%0d] got %b want 1", i, in_yumi); end
      @(posedge clk);
    end
    #1;
    nvec++; if (ret_full !== 1'b1 || credits !== 4'd6) begin nmis++; $display("FAIL full_after_4 full %b credits %0d want 1 6", ret_full, credits); end
    nvec++; if (ret_data !== 32'hA) begin nmis++; $display("FAIL full_head got %h want a", ret_data); end
    @(negedge clk); in_data = 32'hE; in_reg = 4;
    #1;
    nvec++; if (in_yumi !== 1'b0) begin nmis++; $display("FAIL fifth_refused got %b want 0", in_yumi); end
    @(posedge clk); #1;
    nvec++; if (credits !== 4'd6 || ret_full !== 1'b1) begin nmis++; $display("FAIL refused_state credits %0d full %b want 6 1", credits, ret_full); end
    @(negedge clk); in_type = e_return_credit;
    #1;
    nvec++; if (in_yumi !== 1'b1) begin nmis++; $display("FAIL credit_when_full got %b want 1", in_yumi); end
    @(posedge clk); #1;
    nvec++; if (credits !== 4'd7 || ret_full !== 1'b1 || ret_data !== 32'hA)
      begin nmis++; $display("FAIL credit_pkt credits %0d full %b head %h want 7 1 a", credits, ret_full, ret_data); end
  endtask

  task automatic test_full_drain();
    logic [31:0] exp_d;
    @(negedge clk); in_v = 1; in_type = e_return_int_wb; in_data = 32'hE; in_reg = 4; ret_yumi = 1;
    #1;
    nvec++; if (in_yumi !== 1'b0) begin nmis++; $display("FAIL full_deq_no_enq got %b want 0", in_yumi); end
    @(posedge clk); #1;
    nvec++; if (ret_full !== 1'b0 || ret_data !== 32'hB || credits !== 4'd7)
      begin nmis++; $display("FAIL after_deq full %b head %h credits %0d want 0 b 7", ret_full, ret_data, credits); end
    @(negedge clk); ret_yumi = 0;
    #1;
    nvec++; if (in_yumi !== 1'b1) begin nmis++; $display("FAIL retry_accept got %b want 1", in_yumi); end
    @(posedge clk); #1;
    nvec++; if (ret_full !== 1'b1 || credits !== 4'd8) begin nmis++; $display("FAIL refill full %b credits %0d want 1 8", ret_full, credits); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_v = 0; ret_yumi = 1; exp_d = 32'hB + 32'(i);
      #1;
      nvec++; if (ret_v !== 1'b1 || ret_data !== exp_d || ret_reg !== 5'(i + 1))
        begin nmis++; $display("FAIL order[%0d] got v %b %h/%0d want 1 %h/%0d", i, ret_v, ret_data, ret_reg, exp_d, i + 1); end
      @(posedge clk);
    end
    #1;
    nvec++; if (ret_v !== 1'b0) begin nmis++; $display("FAIL drained got v %b want 0", ret_v); end
    @(negedge clk); ret_yumi = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); out_v = 1;
      @(posedge clk);
    end
    #1;
    nvec++; if (credits !== 4'd3) begin nmis++; $display("FAIL credits_to_3 got %0d want 3", credits); end
    @(negedge clk); out_v = 1; in_v = 1; in_type = e_return_int_wb; in_data = 32'h100; in_reg = 0;
    #1;
    nvec++; if (in_yumi !== 1'b1) begin nmis++; $display("FAIL simul_accept got %b want 1", in_yumi); end
    @(posedge clk); #1;
    q.push_back(32'h100);
    nvec++; if (credits !== 4'd3 || ret_v !== 1'b1) begin nmis++; $display("FAIL simul_credits %0d v %b want 3 1", credits, ret_v); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); out_v = 1; in_v = 1; in_data = 32'h100 + 32'(k); in_reg = 5'(k); ret_yumi = 1;
      #1;
      nvec++; if (ret_data !== q[0] || in_yumi !== 1'b1)
        begin nmis++; $display("FAIL wrap_head[%0d] got %h yumi %b want %h 1", k, ret_data, in_yumi, q[0]); end
      @(posedge clk); #1;
      void'(q.pop_front());
      q.push_back(32'h100 + 32'(k));
      nvec++; if (credits !== 4'd3) begin nmis++; $display("FAIL wrap_credits[%0d] got %0d want 3", k, credits); end
    end
    @(negedge clk); out_v = 0; in_v = 0; ret_yumi = 1;
    #1;
    nvec++; if (ret_data !== 32'h114) begin nmis++; $display("FAIL wrap_last got %h want 114", ret_data); end
    @(posedge clk); #1;
    nvec++; if (ret_v !== 1'b0) begin nmis++; $display("FAIL wrap_empty got v %b want 0", ret_v); end
    @(negedge clk); ret_yumi = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_v = 1; in_type = e_return_int_wb; in_data = 32'h55 + 32'(i); in_reg = 5'(i);
      @(posedge clk);
    end
    #1;
    nvec++; if (ret_v !== 1'b1 || credits !== 4'd5) begin nmis++; $display("FAIL pre_reset v %b credits %0d want 1 5", ret_v, credits); end
    @(negedge clk); in_data = 32'h99;
    #2 rst_n = 0;
    #1;
    nvec++; if (ret_v !== 1'b0) begin nmis++; $display("FAIL async_ret_v got %b want 0", ret_v); end
    nvec++; if (credits !== 4'd8 || credits_avail !== 1'b1) begin nmis++; $display("FAIL async_credits got %0d want 8", credits); end
    nvec++; if (in_yumi !== 1'b0 || ret_full !== 1'b0) begin nmis++; $display("FAIL async_yumi_full yumi %b full %b want 0 0", in_yumi, ret_full); end
    @(negedge clk); rst_n = 1; in_v = 0;
    @(posedge clk); #1;
    nvec++; if (ret_v !== 1'b0 || credits !== 4'd8) begin nmis++; $display("FAIL post_reset v %b credits %0d want 0 8", ret_v, credits); end
    @(negedge clk); in_v = 1; out_v = 1; in_data = 32'h77; in_reg = 7;
    @(posedge clk); #1;
    nvec++; if (ret_v !== 1'b1 || ret_data !== 32'h77 || ret_reg !== 5'd7 || credits !== 4'd8)
      begin nmis++; $display("FAIL post_reset_head v %b %h/%0d credits %0d want 1 77/7 8", ret_v, ret_data, ret_reg, credits); end
    @(negedge clk); in_v = 0; out_v = 0; ret_yumi = 1;
    @(posedge clk); #1;
    nvec++; if (ret_v !== 1'b0) begin nmis++; $display("FAIL post_reset_drain got v %b want 0", ret_v); end
    @(negedge clk); ret_yumi = 0;
  endtask

  initial begin
    test_reset();
    test_credit_return();
    test_full();
    test_full_drain();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/vanilla_return_buffer.md
VANILLA_RETURN_BUFFER -- requirements
Module: vanilla_return_buffer

Interface
REQ-001 SHALL have parameter data_width_p, default "inv", meaning the return data width in bits.
REQ-002 SHALL have parameter els_p, default 4, meaning the return FIFO depth; it is a power of two and at least 2.
REQ-003 SHALL have parameter max_out_credits_p, default "inv", meaning the maximum number of outstanding remote requests.
REQ-004 SHALL have local parameter credit_counter_width_lp = clog2(max_out_credits_p+1).
REQ-005 SHALL declare ports as follows, clock and reset first:
- clk_i  in  1  clock; one clock domain.
- reset_n_i  in  1  reset; asynchronous, active-low.
- in_v_i  in  1  return packet valid from endpoint.
- in_data_i  in  data_width_p  return data.
- in_reg_id_i  in  bsg_manycore_reg_id_width_gp  destination register id.
- in_pkt_type_i  in  bsg_manycore_return_packet_type_e  return type.
- in_yumi_o  out  1  return packet consumed this cycle.
- out_v_i  in  1  remote request leaves the tile this cycle; consumes one credit.
- returned_v_o  out  1  FIFO head valid.
- returned_data_o  out  data_width_p  head data.
- returned_reg_id_o  out  bsg_manycore_reg_id_width_gp  head reg id.
- returned_pkt_type_o  out  bsg_manycore_return_packet_type_e  head type.
- returned_fifo_full_o  out  1  FIFO holds els_p entries.
- returned_yumi_i  in  1  head consumed by the TX/response logic.
- out_credits_o  out  credit_counter_width_lp  available credits.
- out_credits_avail_o  out  1  out_credits_o != 0.

Function
REQ-006 SHALL accept a packet (in_yumi_o=1) when in_v_i=1 and either in_pkt_type_i == e_return_credit or the FIFO is not full.
- in_yumi_o depends only on registered state and in_v_i/in_pkt_type_i, never on returned_yumi_i.
REQ-007 SHALL drop credit-type packets without enqueueing them.
REQ-008 SHALL enqueue every other accepted packet as {data, reg_id, pkt_type}.
REQ-009 SHALL use enqueue-to-head latency of exactly 1 cycle with no combinational bypass.
- An entry written at edge N appears on returned_v_o after edge N.
REQ-010 SHALL hold returned_* stable until returned_yumi_i is asserted.
REQ-011 SHALL dequeue the head on returned_yumi_i & returned_v_o.
- returned_yumi_i while empty is ignored.
REQ-012 SHALL handle simultaneous enqueue and dequeue when the FIFO is non-empty and not full: occupancy unchanged, order preserved.
- When full, the dequeue occurs and the enqueue is refused that cycle (see REQ-006).
REQ-013 SHALL wrap read and write pointers modulo els_p.
- Full and empty are distinguished by an extra pointer MSB or an occupancy counter of width clog2(els_p+1).
REQ-014 SHALL drive returned_fifo_full_o = (occupancy == els_p) from registered state.
REQ-015 SHALL update the credit counter as follows:
- decrement on out_v_i;
- increment on in_v_i & in_yumi_o (any type, credit packets included);
- both in the same cycle leaves it unchanged.
REQ-016 SHALL saturate the credit counter: no decrement at 0 and no increment at max_out_credits_p; either event fires a simulation-only error.
REQ-017 SHALL fire a simulation-only error if returned_fifo_full_o is asserted and returned_yumi_i is not asserted in the same cycle.

Reset
REQ-018 SHALL, while reset_n_i=0, asynchronously drive:
- pointers and occupancy to 0;
- out_credits_o = max_out_credits_p and out_credits_avail_o=1;
- returned_v_o=0 and returned_fifo_full_o=0;
- in_yumi_o=0.
REQ-019 SHALL discard all FIFO contents on reset mid-operation.
- FIFO storage needs no reset; returned_data_o, returned_reg_id_o and returned_pkt_type_o are don't-care while returned_v_o=0.
REQ-020 SHALL begin normal operation on the first rising clk_i edge after reset_n_i deasserts.

Structure
REQ-021 SHALL take bsg_manycore_return_packet_type_e and bsg_manycore_reg_id_width_gp from bsg_manycore_pkg and add no new package types.
REQ-022 SHALL place storage and pointers in one sub-module, vanilla_return_fifo_ar (1r1w, async active-low reset).
- The credit counter and accept logic stay in the top module.

Verification
REQ-023 SHALL cover: after reset, els_p=4, max=8, idle -> out_credits_o=8, returned_v_o=0, in_yumi_o=0.
REQ-024 SHALL cover: 3 out_v_i pulses, then an int return of data 0xDEADBEEF, reg 5 -> credits 8,7,6,5 then 6; head shows 0xDEADBEEF/5 one cycle after in_yumi_o.
REQ-025 SHALL cover: 4 returns with returned_yumi_i=0, then a 5th -> full=1 after the 4th; 5th in_yumi_o=0; a credit packet in the same state is accepted and credits +1.
REQ-026 SHALL cover: full FIFO, returned_yumi_i=1 while in_v_i=1 -> one dequeue, no enqueue; next cycle enqueue accepted; order A,B,C,D,E preserved.
REQ-027 SHALL cover: out_v_i and an accepted return in the same cycle at credits=3 -> credits stay 3; over 20 cycles of interleaving, pointer wrap loses no data.
REQ-028 SHALL cover: reset_n_i low for 1 cycle mid-traffic with 2 entries held -> returned_v_o=0 immediately (asynchronously) and credits return to 8.
